// File: rtl/rice_riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rice_riscv_pkg
// Purpose  : RV32I opcode / instruction-format types, decoded-instruction
//            record and decode helper functions shared by the decode stage.
// Revision : 1.0  initial release
// ============================================================================
package rice_riscv_pkg;

  localparam int c_XLEN = 32;

  // Major opcodes of the RV32I base set (inst[6:0])
  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } rice_riscv_opcode;

  // Instruction formats; R doubles as the fallback for unknown opcodes
  typedef enum logic [2:0] {
    INST_R = 3'd0,
    INST_I = 3'd1,
    INST_S = 3'd2,
    INST_B = 3'd3,
    INST_U = 3'd4,
    INST_J = 3'd5
  } rice_riscv_inst_type;

  typedef logic [31:0] rice_riscv_inst;

  // Opcode is kept as a raw vector so illegal encodings survive unchanged
  typedef struct packed {
    logic [c_XLEN-1:0]   pc;
    rice_riscv_inst      inst;
    logic [6:0]          opcode;
    rice_riscv_inst_type inst_type;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [c_XLEN-1:0]   imm;
    logic                illegal;
  } rice_riscv_decoded;

  function automatic logic is_legal_opcode(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic rice_riscv_inst_type get_inst_type(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC:                                  return INST_U;
      OPC_JAL:                                             return INST_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM,
      OPC_SYSTEM:                                          return INST_I;
      OPC_BRANCH:                                          return INST_B;
      OPC_STORE:                                           return INST_S;
      default:                                             return INST_R;
    endcase
  endfunction

  // Sign bit of every immediate is inst[31]
  function automatic logic [c_XLEN-1:0] get_imm(input rice_riscv_inst      inst,
                                                input rice_riscv_inst_type inst_type);
    case (inst_type)
      INST_I:  return {{20{inst[31]}}, inst[31:20]};
      INST_S:  return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      INST_B:  return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      INST_U:  return {inst[31:12], 12'b0};
      INST_J:  return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rice_inst_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rice_inst_decoder
// Purpose  : Purely combinational RV32I field decoder: raw word + pc in,
//            decoded record out.
// Revision : 1.0  initial release
// ============================================================================
module rice_inst_decoder
  import rice_riscv_pkg::*;
(
  input  logic [c_XLEN-1:0] i_pc,
  input  logic [31:0]       i_inst,
  output rice_riscv_decoded o_decoded
);

  rice_riscv_inst_type w_type;
  logic                w_has_rs1;
  logic                w_has_rs2;
  logic                w_has_rd;

  // Format lookup and register-field presence per format
  always_comb begin
    w_type    = get_inst_type(i_inst[6:0]);
    w_has_rs1 = (w_type == INST_R) || (w_type == INST_I) ||
                (w_type == INST_S) || (w_type == INST_B);
    w_has_rs2 = (w_type == INST_R) || (w_type == INST_S) || (w_type == INST_B);
    w_has_rd  = (w_type == INST_R) || (w_type == INST_I) ||
                (w_type == INST_U) || (w_type == INST_J);
  end

  // Assemble the decoded record; absent register fields read as x0
  always_comb begin
    o_decoded.pc        = i_pc;
    o_decoded.inst      = i_inst;
    o_decoded.opcode    = i_inst[6:0];
    o_decoded.inst_type = w_type;
    o_decoded.rs1       = w_has_rs1 ? i_inst[19:15] : 5'd0;
    o_decoded.rs2       = w_has_rs2 ? i_inst[24:20] : 5'd0;
    o_decoded.rd        = w_has_rd  ? i_inst[11:7]  : 5'd0;
    o_decoded.imm       = get_imm(i_inst, w_type);
    o_decoded.illegal   = (i_inst[1:0] != 2'b11) || !is_legal_opcode(i_inst[6:0]);
  end

endmodule
`default_nettype wire

// File: rtl/rice_core_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rice_core_decode_stage
// Purpose  : Decode pipeline stage between fetch and execute. Decodes the
//            incoming word combinationally and stores the result in a
//            2-entry skid buffer so that o_ready is a pure register output.
// Revision : 1.0  initial release
// ============================================================================
module rice_core_decode_stage
  import rice_riscv_pkg::*;
#(
  parameter int              XLEN     = 32,   // only 32 (RV32I) is supported
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_inst,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_inst_type,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  // Buffer occupancy: MAIN drives the outputs, SKID absorbs one overflow
  localparam logic [1:0] c_ST_EMPTY = 2'd0;
  localparam logic [1:0] c_ST_ONE   = 2'd1;
  localparam logic [1:0] c_ST_FULL  = 2'd2;

  localparam rice_riscv_decoded c_RESET_ENTRY = '{
    pc:        RESET_PC,
    inst:      32'd0,
    opcode:    7'd0,
    inst_type: INST_R,
    rs1:       5'd0,
    rs2:       5'd0,
    rd:        5'd0,
    imm:       '0,
    illegal:   1'b0
  };

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_ready;
  rice_riscv_decoded r_main;
  rice_riscv_decoded r_skid;
  rice_riscv_decoded w_dec;
  logic              w_valid;
  logic              w_in;
  logic              w_out;

  rice_inst_decoder u_decoder (
    .i_pc      (i_pc),
    .i_inst    (i_inst),
    .o_decoded (w_dec)
  );

  assign w_valid = (r_state != c_ST_EMPTY);
  assign w_in    = i_valid & r_ready;
  assign w_out   = w_valid & i_ready;

  // Next buffer state; a flush overrides every transfer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_EMPTY: if (w_in) w_state_nxt = c_ST_ONE;
      c_ST_ONE: begin
        if (w_in && !w_out)      w_state_nxt = c_ST_FULL;
        else if (!w_in && w_out) w_state_nxt = c_ST_EMPTY;
      end
      c_ST_FULL:  if (w_out) w_state_nxt = c_ST_ONE;
      default:    w_state_nxt = c_ST_EMPTY;
    endcase
    if (i_flush) w_state_nxt = c_ST_EMPTY;
  end

  // State, registered ready and entry loading; entries only move on a transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_ST_EMPTY;
      r_ready <= 1'b1;
      r_main  <= c_RESET_ENTRY;
      r_skid  <= c_RESET_ENTRY;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != c_ST_FULL);
      if (!i_flush) begin
        case (r_state)
          c_ST_EMPTY: if (w_in) r_main <= w_dec;
          c_ST_ONE: begin
            if (w_in && w_out) r_main <= w_dec;
            else if (w_in)     r_skid <= w_dec;
          end
          c_ST_FULL:  if (w_out) r_main <= r_skid;
          default: ;
        endcase
      end
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = w_valid;
  assign o_pc        = r_main.pc;
  assign o_inst      = r_main.inst;
  assign o_opcode    = r_main.opcode;
  assign o_inst_type = r_main.inst_type;
  assign o_rs1       = r_main.rs1;
  assign o_rs2       = r_main.rs2;
  assign o_rd        = r_main.rd;
  assign o_imm       = r_main.imm;
  assign o_illegal   = r_main.illegal;

endmodule
`default_nettype wire
